// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_mem_pkg
//  Brief    : Shared types and defaults for the MIPS byte memory responder.
//  Revision : 1.0 - initial release
// ============================================================================
package mips_mem_pkg;

   // Default bus geometry of the 8-bit multicycle MIPS core.
   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;
   localparam int RAM_DEPTH  = 2 ** ADDR_W_DEF;

   // Responder mode: LOAD fills RAM from the boot stream, RUN serves the core.
   typedef enum logic [0:0] {
      LOAD = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage : mips_mem_pkg
`default_nettype wire

// File: rtl/mips_mem_responder_byte_ram.sv
`default_nettype none
// ============================================================================
//  Module   : byte_ram
//  Brief    : Single-port RAM, synchronous write, registered read. A write
//             in the same cycle as a read wins and the read register holds.
//  Revision : 1.0 - initial release
// ============================================================================
module byte_ram #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              re,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // Storage array: never reset, contents survive a reset of the responder.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   // Read register: updated only on a pure read, otherwise holds for the core.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata <= '0;
      end else if (re && !we) begin
         rdata <= mem[addr];
      end
   end

endmodule : byte_ram
`default_nettype wire

// File: rtl/mips_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mips_mem_responder
//  Brief    : Byte memory for the multicycle MIPS core with a boot loader that
//             fills RAM from a byte stream and holds the core in reset until
//             the load completes.
//  Revision : 1.0 - initial release
// ============================================================================
module mips_mem_responder
   import mips_mem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              memread,
   input  logic              memwrite,
   input  logic [ADDR_W-1:0] adr,
   input  logic [DATA_W-1:0] writedata,
   output logic [DATA_W-1:0] memdata,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   input  logic              load_skip,
   output logic              load_ready,
   output logic              core_reset,
   output logic [ADDR_W:0]   load_count
);

   localparam logic [ADDR_W-1:0] PTR_LAST  = '1;
   localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

   state_t              state;
   state_t              state_next;
   logic [ADDR_W-1:0]   load_ptr;
   logic [ADDR_W:0]     count_q;
   logic                accept;

   logic                ram_re;
   logic                ram_we;
   logic [ADDR_W-1:0]   ram_addr;
   logic [DATA_W-1:0]   ram_wdata;

   // A skip in the same cycle suppresses the byte, so it never counts as accepted.
   assign accept = (state == LOAD) && load_valid && !load_skip;

   // Both handshake outputs come straight from the state flop: no glitches.
   assign load_ready = (state == LOAD);
   assign core_reset = (state == LOAD);
   assign load_count = count_q;

   // State register; reset is the only way back into LOAD.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= LOAD;
      end else begin
         state <= state_next;
      end
   end

   // Next-state: leave LOAD on skip, on the tagged last byte, or when RAM is full.
   always_comb begin
      state_next = state;
      unique case (state)
         LOAD: begin
            if (load_skip) begin
               state_next = RUN;
            end else if (load_valid && (load_last || (load_ptr == PTR_LAST))) begin
               state_next = RUN;
            end
         end
         RUN: begin
            state_next = RUN;
         end
         default: begin
            state_next = LOAD;
         end
      endcase
   end

   // Loader pointer and saturating accepted-byte counter; count persists in RUN.
   always_ff @(posedge clk) begin
      if (reset) begin
         load_ptr <= '0;
         count_q  <= '0;
      end else if (accept) begin
         load_ptr <= load_ptr + 1'b1;
         if (count_q != COUNT_MAX) begin
            count_q <= count_q + 1'b1;
         end
      end
   end

   // RAM port mux: loader owns the port in LOAD, the core owns it in RUN.
   always_comb begin
      ram_re    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = adr;
      ram_wdata = writedata;
      if (state == LOAD) begin
         ram_we    = accept;
         ram_addr  = load_ptr;
         ram_wdata = load_data;
      end else begin
         ram_re = memread;
         ram_we = memwrite;
      end
   end

   byte_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk   (clk),
      .reset (reset),
      .re    (ram_re),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (memdata)
   );

endmodule : mips_mem_responder
`default_nettype wire

// File: doc/mips_mem_responder.md
# mips_mem_responder

Byte-wide memory responder for the multicycle 8-bit MIPS controller and datapath. It services the core's `memread`/`memwrite` strobes on the shared address/data bus and returns read data with one cycle of latency. A boot loader FSM fills the RAM from a byte stream after reset and holds the core in reset until the load completes.

## Interface
- `ADDR_W`, 8: address width; RAM depth is 2**ADDR_W bytes.
- `DATA_W`, 8: data width; matches the core's byte bus.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; returns FSM to LOAD, pointer 0.
- `memread`  in  1  core read strobe.
- `memwrite`  in  1  core write strobe.
- `adr`  in  ADDR_W  core byte address.
- `writedata`  in  DATA_W  core store data.
- `memdata`  out  DATA_W  registered read data to the core.
- `load_valid`  in  1  loader byte available.
- `load_data`  in  DATA_W  loader byte.
- `load_last`  in  1  qualifies the final loader byte.
- `load_skip`  in  1  leave LOAD without writing (RAM keeps its contents).
- `load_ready`  out  1  high in LOAD; a byte is accepted when `load_valid & load_ready`.
- `core_reset`  out  1  drives the core's reset; high in LOAD.
- `load_count`  out  ADDR_W+1  number of bytes accepted since the last reset.

## Operation
- FSM states: LOAD, RUN. `reset` forces LOAD. Reset has no other path out of RUN.
- LOAD:
  - Each accepted byte is written to `mem[load_ptr]`, then `load_ptr` and `load_count` increment.
  - Transition to RUN on the edge that accepts a byte with `load_last=1`, or accepts a byte at `load_ptr = 2**ADDR_W-1`, or samples `load_skip=1`.
  - `load_skip` takes priority over a same-cycle byte; that byte is not written.
  - Core strobes are ignored in LOAD.
- RUN:
  - `memwrite=1`: `mem[adr] <= writedata`.
  - `memread=1 & memwrite=0`: `memdata <= mem[adr]`.
  - Both strobes high: the write wins and `memdata` holds.
  - Neither strobe high: `memdata` holds its last value, because the core captures across consecutive fetch states.
  - Loader inputs are ignored and `load_ready=0`.
- `load_count` saturates at 2**ADDR_W and is not cleared on entry to RUN.
- `core_reset` and `load_ready` are decoded from the state register only, so they are glitch-free.
- Reset mid-load: the pointer returns to 0; bytes already written remain in RAM and are overwritten by the new load.
- Reset in RUN: the core is held in reset again and RAM is not cleared.

## Timing
- Reset values:
  - state LOAD
  - `memdata` 0
  - `load_count` 0
  - `load_ready` 1 (first cycle after reset deasserts)
  - `core_reset` 1
- Read latency: `memread` and `adr` sampled at edge N produce `memdata` valid after edge N, for the whole of cycle N+1.
- Write then read of the same address on the next cycle returns the new data; there is no bypass hazard.
- `core_reset` falls on the edge following acceptance of the last byte. The core's first fetch reads address 0 one cycle later.
- Loader throughput: 1 byte per cycle.

## Structure
- Shared package `mips_mem_pkg`:
  - state enum `{LOAD, RUN}`
  - `ADDR_W`/`DATA_W` defaults
  - RAM depth constant
- Sub-module `byte_ram`: single-port synchronous-write, registered-read array with read-enable/write-enable and write-priority.
- The top level owns the FSM, the pointer/count, and the mux of the RAM port between loader and core.

## Test plan
- Reset, then load bytes 0x20,0x02,0x00,0x05 with `load_last` on the 4th:
  - `core_reset` falls the cycle after the 4th byte.
  - `load_count`=4.
  - Core reads of adr 0..3 return 0x20,0x02,0x00,0x05, each one cycle after `memread`.
- In RUN, write 0xA5 to adr 0x40, then `memread` adr 0x40 the next cycle: `memdata`=0xA5 one cycle later.
- `memread` then idle 3 cycles: `memdata` holds. `memread&memwrite` to 0x10 with 0x3C: RAM[0x10]=0x3C and `memdata` unchanged.
- Load 256 bytes without `load_last`: RUN entered after the 256th byte, `load_count`=256, RAM[0xFF] holds the last byte.
- Assert `reset` after 2 of 4 bytes, then reload 0x11,0x22: RAM[0..1]=0x11,0x22 and `load_count`=2.
- `load_skip` with `load_valid` high in the same cycle: RUN next cycle, RAM unchanged, `load_count`=0.
